ejector: RTL and testbench
==========================

Name: ejector

Overview:
- Counterpart to the injector in the bufferless mesh router. The injector places a locally generated flit into a free input slot; the ejector removes flits addressed to this node.
- Sits on the router input stage, before route computation.
- Each cycle it examines the four incoming slots (north, south, east, west) and selects at most one flit whose destination equals this node. It frees that slot for downstream and injection, and pushes the flit into a small local ejection FIFO drained by the core with a valid/ready handshake.

Parameters:
- LOCAL_ROW, 3'd4: this node's row, compared with addr[5:3].
- LOCAL_COL, 3'd4: this node's column, compared with addr[2:0].
- DATA_W, 16: payload width carried alongside the 6-bit address.
- FIFO_DEPTH, 4: ejection FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- northad, southad, eastad, westad  in  6 each  incoming flit address {row[5:3], col[2:0]}
- north_valid, south_valid, east_valid, west_valid  in  1 each  slot occupied
- north_data, south_data, east_data, west_data  in  DATA_W each  incoming payload
- nad, sad, ead, wad  out  6 each  forwarded address, registered
- n_valid, s_valid, e_valid, w_valid  out  1 each  forwarded slot occupied, registered
- n_data, s_data, e_data, w_data  out  DATA_W each  forwarded payload, registered
- local_valid  out  1  ejection FIFO non-empty
- local_ad  out  6  head flit address
- local_data  out  DATA_W  head flit payload
- local_ready  in  1  core accepts the head flit
- eject_port  out  4  one-hot port ejected in the last cycle (bit 0 E, 1 W, 2 N, 3 S); 0 if none
- fifo_full  out  1  ejection FIFO full (status only)

Behaviour:
- Reset: applied asynchronously while rst_n=0.
  - All forwarded valid bits, local_valid, eject_port and fifo_full go to 0.
  - Forwarded address and data registers clear to 0.
  - FIFO read/write pointers and count go to 0.
  - Round-robin pointer goes to E (bit 0).
  - Reset mid-operation discards all buffered flits.
- Match: port p matches when p_valid=1 and addr[5:3]==LOCAL_ROW and addr[2:0]==LOCAL_COL.
- Arbitration:
  - Among matching ports, pick the first at or after the round-robin pointer, in order E, W, N, S, wrapping.
  - After a successful ejection, the pointer moves to the port following the winner.
  - Otherwise the pointer is unchanged.
- Ejection happens only when the FIFO can accept it: count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop this cycle (local_valid & local_ready).
  - If the FIFO cannot accept, no port is ejected. All matching flits are forwarded unchanged and get deflected by the router.
- Forwarding latency is 1 cycle.
  - Each forwarded output register loads its input address and data.
  - Its valid loads p_valid & ~ejected_p.
  - An ejected slot forwards valid=0, with the address still passed through (don't-care).
- Non-matching flits are never modified. At most one flit is ejected per cycle, even when all four ports match.
- eject_port is registered and asserts the one-hot winner in the cycle the forwarded outputs update.
- FIFO:
  - First-word-fall-through: local_ad and local_data show the head entry whenever local_valid=1.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - An ejected flit becomes visible on local_valid one cycle after its input cycle, when the FIFO was empty.
  - Head data stays stable while local_valid=1 and local_ready=0.
- fifo_full equals (count==FIFO_DEPTH), registered with the count.
- No handshake toward the network: slots are consumed every cycle (bufferless).

Decomposition:
- Shared package:
  - Address field slices ROW_MSB=5, ROW_LSB=3, COL_MSB=2, COL_LSB=0.
  - Direction index constants DIR_E=0, DIR_W=1, DIR_N=2, DIR_S=3, DIR_L=4. Same encoding as the injector's one-hot dir.
  - Flit struct {addr[5:0], data}.
- One sub-module: eject_fifo. A parameterised synchronous FWFT FIFO with async active-low reset, exposing push, pop, full, empty and count.
- Arbitration and forwarding registers stay in ejector.

Test Plan:
1. Single match:
   - Stimulus: north_valid=1, northad=6'b100100, others invalid.
   - Next cycle: n_valid=0, eject_port=4'b0100, local_valid=1, local_ad=6'b100100, with the data matching.
2. No match:
   - Stimulus: all four valid, addresses 6'b000001/6'b111000/6'b100011/6'b010100.
   - Next cycle: all forwarded valid=1 with identical addresses; eject_port=0; local_valid=0.
3. Four-way contention over four consecutive cycles:
   - Stimulus: all ports carry 6'b100100; local_ready=1.
   - Winners must be E, W, N, S in turn, one per cycle. The three losing slots stay valid each cycle.
4. FIFO full:
   - Stimulus: local_ready=0; inject 4 matching flits on E in successive cycles, then a 5th.
   - Response: fifo_full=1 after the 4th. The 5th is forwarded with e_valid=1 and eject_port=0.
   - Then assert local_ready=1 and present a 6th matching flit in the same cycle. It is ejected (pop and push together) and count stays 4.
5. Drain order:
   - Stimulus: fill the FIFO with data 1, 2, 3, then local_ready=1 for 3 cycles.
   - Response: local_data shows 1, 2, 3 in order, then local_valid=0.
6. Reset mid-operation:
   - Stimulus: with 2 FIFO entries and the pointer at N, pull rst_n low between clock edges.
   - Response: immediately local_valid=0, all forwarded valid=0, eject_port=0.
   - After release, a 4-way match ejects E first.

Source files
------------

// File: rtl/ejector_pkg.sv
// Shared definitions for the router ejection stage: address field slices,
// port direction indices and the flit record.
package ejector_pkg;
   localparam int ADDR_W    = 6;
   localparam int ROW_MSB   = 5;
   localparam int ROW_LSB   = 3;
   localparam int COL_MSB   = 2;
   localparam int COL_LSB   = 0;
   localparam int NUM_PORTS = 4;

   localparam int DIR_E = 0;
   localparam int DIR_W = 1;
   localparam int DIR_N = 2;
   localparam int DIR_S = 3;
   localparam int DIR_L = 4;

   localparam int FLIT_DATA_W = 16;

   typedef struct packed {
      logic [ADDR_W-1:0]      addr;
      logic [FLIT_DATA_W-1:0] data;
   } flit_t;

   function automatic logic addr_match(input logic [ADDR_W-1:0] a,
                                       input logic [2:0] row,
                                       input logic [2:0] col);
      return (a[ROW_MSB:ROW_LSB] == row) && (a[COL_MSB:COL_LSB] == col);
   endfunction
endpackage

// File: rtl/eject_fifo.sv
// First-word-fall-through FIFO holding flits ejected to the local core.
module eject_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rptr, wptr;
   logic             do_push, do_pop;
   logic [CW-1:0]    count_next;

   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a full FIFO still takes a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   always_comb begin
      count_next = count + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         full  <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
      end
   end
endmodule

// File: rtl/ejector.sv
// Router input-stage ejector: removes at most one flit per cycle addressed to
// this node (round-robin E,W,N,S) and forwards the remaining slots.
module ejector
   import ejector_pkg::*;
#(
   parameter logic [2:0] LOCAL_ROW = 3'd4,
   parameter logic [2:0] LOCAL_COL = 3'd4,
   parameter int DATA_W = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        northad, southad, eastad, westad,
   input  logic              north_valid, south_valid, east_valid, west_valid,
   input  logic [DATA_W-1:0] north_data, south_data, east_data, west_data,
   output logic [5:0]        nad, sad, ead, wad,
   output logic              n_valid, s_valid, e_valid, w_valid,
   output logic [DATA_W-1:0] n_data, s_data, e_data, w_data,
   output logic              local_valid,
   output logic [5:0]        local_ad,
   output logic [DATA_W-1:0] local_data,
   input  logic              local_ready,
   output logic [3:0]        eject_port,
   output logic              fifo_full
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_PORTS-1:0]             in_v, match, grant;
   logic [NUM_PORTS-1:0][5:0]        in_a, fwd_a;
   logic [NUM_PORTS-1:0][DATA_W-1:0] in_d, fwd_d;
   logic [NUM_PORTS-1:0]             fwd_v;
   logic [1:0]                       rr_ptr, idx, win_idx;
   logic                             found, pop, can_accept, empty;
   logic [CW-1:0]                    count;
   logic [6+DATA_W-1:0]              head;

   assign in_v = {south_valid, north_valid, west_valid, east_valid};
   assign in_a = {southad, northad, westad, eastad};
   assign in_d = {south_data, north_data, west_data, east_data};

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++)
         match[p] = in_v[p] & addr_match(in_a[p], LOCAL_ROW, LOCAL_COL);
   end

   assign pop        = local_valid & local_ready;
   assign can_accept = (count < CW'(FIFO_DEPTH)) | pop;

   always_comb begin
      grant   = '0;
      found   = 1'b0;
      idx     = '0;
      win_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = rr_ptr + 2'(k);
         if (!found && can_accept && match[idx]) begin
            grant[idx] = 1'b1;
            win_idx    = idx;
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= 2'(DIR_E);
         fwd_v      <= '0;
         fwd_a      <= '0;
         fwd_d      <= '0;
         eject_port <= '0;
      end else begin
         if (found) rr_ptr <= win_idx + 2'd1;
         fwd_v      <= in_v & ~grant;
         fwd_a      <= in_a;
         fwd_d      <= in_d;
         eject_port <= grant;
      end
   end

   eject_fifo #(.WIDTH(6 + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (found),
      .pop   (pop),
      .wdata ({in_a[win_idx], in_d[win_idx]}),
      .rdata (head),
      .full  (fifo_full),
      .empty (empty),
      .count (count)
   );

   assign local_valid = ~empty;
   assign local_ad    = head[6+DATA_W-1:DATA_W];
   assign local_data  = head[DATA_W-1:0];

   assign {s_valid, n_valid, w_valid, e_valid} = fwd_v;
   assign ead = fwd_a[DIR_E];
   assign wad = fwd_a[DIR_W];
   assign nad = fwd_a[DIR_N];
   assign sad = fwd_a[DIR_S];
   assign e_data = fwd_d[DIR_E];
   assign w_data = fwd_d[DIR_W];
   assign n_data = fwd_d[DIR_N];
   assign s_data = fwd_d[DIR_S];
endmodule

// File: tb/tb_ejector.sv
// Self-checking bench for ejector: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ejector;
   import ejector_pkg::*;

   localparam logic [5:0] LOC = 6'b100100;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        tv [4];
   logic [5:0]  ta [4];
   logic [15:0] td [4];
   logic        ready;

   logic        ov [4];
   logic [5:0]  oa [4];
   logic [15:0] od [4];
   logic        local_valid, fifo_full;
   logic [5:0]  local_ad;
   logic [15:0] local_data;
   logic [3:0]  eject_port;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   flit_t mq[$];
   int    m_ptr;
   logic  exp_v [4];
   logic [5:0]  exp_a [4];
   logic [15:0] exp_d [4];
   logic [3:0]  exp_ej;

   ejector dut (
      .clk(clk), .rst_n(rst_n),
      .northad(ta[DIR_N]), .southad(ta[DIR_S]), .eastad(ta[DIR_E]), .westad(ta[DIR_W]),
      .north_valid(tv[DIR_N]), .south_valid(tv[DIR_S]), .east_valid(tv[DIR_E]), .west_valid(tv[DIR_W]),
      .north_data(td[DIR_N]), .south_data(td[DIR_S]), .east_data(td[DIR_E]), .west_data(td[DIR_W]),
      .nad(oa[DIR_N]), .sad(oa[DIR_S]), .ead(oa[DIR_E]), .wad(oa[DIR_W]),
      .n_valid(ov[DIR_N]), .s_valid(ov[DIR_S]), .e_valid(ov[DIR_E]), .w_valid(ov[DIR_W]),
      .n_data(od[DIR_N]), .s_data(od[DIR_S]), .e_data(od[DIR_E]), .w_data(od[DIR_W]),
      .local_valid(local_valid), .local_ad(local_ad), .local_data(local_data),
      .local_ready(ready), .eject_port(eject_port), .fifo_full(fifo_full)
   );

   task automatic idle_inputs();
      for (int p = 0; p < 4; p++) begin
         tv[p] = 1'b0;
         ta[p] = 6'h00;
         td[p] = 16'h0000;
      end
   endtask

   // Advance one clock: compute the expected response from the rules, then
   // let the DUT take the edge and return 1 time unit after it.
   task automatic step();
      int  win;
      bit  pop, acc;
      flit_t f;
      pop = (mq.size() > 0) && ready;
      acc = (mq.size() < DEPTH) || pop;
      win = -1;
      for (int k = 0; k < 4; k++) begin
         int p;
         p = (m_ptr + k) % 4;
         if (win < 0 && acc && tv[p] && ta[p] == LOC) win = p;
      end
      exp_ej = 4'b0000;
      for (int p = 0; p < 4; p++) begin
         exp_v[p] = tv[p] && (p != win);
         exp_a[p] = ta[p];
         exp_d[p] = td[p];
      end
      if (pop) void'(mq.pop_front());
      if (win >= 0) begin
         exp_ej[win] = 1'b1;
         m_ptr = (win + 1) % 4;
         f.addr = ta[win];
         f.data = td[win];
         mq.push_back(f);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle_inputs();
      ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      ready = 1'b0;
      rst_n = 1'b0;
      mq.delete();
      m_ptr = 0;
      #12;
      n_chk++;
      if (local_valid !== 1'b0 || eject_port !== 4'b0 || fifo_full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: lv=%b ej=%b full=%b want 0/0000/0", local_valid, eject_port, fifo_full);
      end
      n_chk++;
      if ({ov[0], ov[1], ov[2], ov[3]} !== 4'b0 || oa[DIR_N] !== 6'h0 || od[DIR_S] !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_fwd: v=%b%b%b%b nad=%h sdata=%h want zeros", ov[0], ov[1], ov[2], ov[3], oa[DIR_N], od[DIR_S]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_contention();
      logic [3:0] want [4];
      want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000;
      ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         for (int p = 0; p < 4; p++) begin
            tv[p] = 1'b1;
            ta[p] = LOC;
            td[p] = 16'(16'h100 * (c + 1) + p);
         end
         step();
         n_chk++;
         if (eject_port !== want[c]) begin
            n_fail++;
            $display("FAIL contention_winner[%0d]: got %b want %b", c, eject_port, want[c]);
         end
         n_chk++;
         if ({ov[3], ov[2], ov[1], ov[0]} !== ~want[c]) begin
            n_fail++;
            $display("FAIL contention_fwd[%0d]: got %b%b%b%b want %b", c, ov[3], ov[2], ov[1], ov[0], ~want[c]);
         end
         n_chk++;
         if (local_valid !== 1'b1 || local_data !== exp_d[$clog2(want[c])]) begin
            n_fail++;
            $display("FAIL contention_head[%0d]: lv=%b data=%h want 1/%h", c, local_valid, local_data, exp_d[$clog2(want[c])]);
         end
      end
      drain();
   endtask

   task automatic test_single_match();
      idle_inputs();
      ready = 1'b0;
      tv[DIR_N] = 1'b1;
      ta[DIR_N] = 6'b100100;
      td[DIR_N] = 16'hBEEF;
      step();
      n_chk++;
      if (ov[DIR_N] !== 1'b0 || eject_port !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_match: n_valid=%b ej=%b want 0/0100", ov[DIR_N], eject_port);
      end
      n_chk++;
      if (local_valid !== 1'b1 || local_ad !== 6'b100100 || local_data !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL single_head: lv=%b ad=%b data=%h want 1/100100/beef", local_valid, local_ad, local_data);
      end
      drain();
   endtask

   task automatic test_no_match();
      logic [5:0] adr [4];
      adr[0] = 6'b000001; adr[1] = 6'b111000; adr[2] = 6'b100011; adr[3] = 6'b010100;
      for (int p = 0; p < 4; p++) begin
         tv[p] = 1'b1;
         ta[p] = adr[p];
         td[p] = 16'(16'hA000 + p);
      end
      step();
      for (int p = 0; p < 4; p++) begin
         n_chk++;
         if (ov[p] !== 1'b1 || oa[p] !== adr[p] || od[p] !== 16'(16'hA000 + p)) begin
            n_fail++;
            $display("FAIL no_match_fwd[%0d]: v=%b a=%b d=%h want 1/%b/%h", p, ov[p], oa[p], od[p], adr[p], 16'(16'hA000 + p));
         end
      end
      n_chk++;
      if (eject_port !== 4'b0 || local_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL no_match_ej: ej=%b lv=%b want 0000/0", eject_port, local_valid);
      end
      idle_inputs();
   endtask

   task automatic test_fifo_full();
      idle_inputs();
      ready = 1'b0;
      tv[DIR_E] = 1'b1;
      ta[DIR_E] = LOC;
      for (int i = 1; i <= 4; i++) begin
         td[DIR_E] = 16'(16'hF000 + i);
         step();
      end
      n_chk++;
      if (fifo_full !== 1'b1) begin
         n_fail++;
         $display("FAIL full_after4: fifo_full=%b want 1", fifo_full);
      end
      td[DIR_E] = 16'hF005;
      step();
      n_chk++;
      if (ov[DIR_E] !== 1'b1 || eject_port !== 4'b0000 || od[DIR_E] !== 16'hF005) begin
         n_fail++;
         $display("FAIL full_deflect: e_valid=%b ej=%b data=%h want 1/0000/f005", ov[DIR_E], eject_port, od[DIR_E]);
      end
      ready = 1'b1;
      td[DIR_E] = 16'hF006;
      step();
      n_chk++;
      if (ov[DIR_E] !== 1'b0 || eject_port !== 4'b0001 || fifo_full !== 1'b1 || local_data !== 16'hF002) begin
         n_fail++;
         $display("FAIL full_pushpop: e_valid=%b ej=%b full=%b head=%h want 0/0001/1/f002", ov[DIR_E], eject_port, fifo_full, local_data);
      end
      drain();
   endtask

   task automatic test_drain_order();
      idle_inputs();
      ready = 1'b0;
      tv[DIR_E] = 1'b1;
      ta[DIR_E] = LOC;
      for (int i = 1; i <= 3; i++) begin
         td[DIR_E] = 16'(i);
         step();
      end
      idle_inputs();
      ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         n_chk++;
         if (local_valid !== 1'b1 || local_data !== 16'(i)) begin
            n_fail++;
            $display("FAIL drain_order[%0d]: lv=%b data=%h want 1/%h", i, local_valid, local_data, 16'(i));
         end
         step();
      end
      n_chk++;
      if (local_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: lv=%b want 0", local_valid);
      end
      ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      ready = 1'b0;
      tv[DIR_E] = 1'b1; ta[DIR_E] = LOC; td[DIR_E] = 16'h0E0E;
      step();
      tv[DIR_E] = 1'b0;
      tv[DIR_W] = 1'b1; ta[DIR_W] = LOC; td[DIR_W] = 16'h0F0F;
      tv[DIR_S] = 1'b1; ta[DIR_S] = 6'h00;
      step();
      // two entries buffered, pointer now at N, S slot still forwarding
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (local_valid !== 1'b0 || eject_port !== 4'b0 || {ov[0], ov[1], ov[2], ov[3]} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_mid: lv=%b ej=%b v=%b%b%b%b want 0/0000/0000", local_valid, eject_port, ov[0], ov[1], ov[2], ov[3]);
      end
      mq.delete();
      m_ptr = 0;
      #2;
      rst_n = 1'b1;
      for (int p = 0; p < 4; p++) begin
         tv[p] = 1'b1;
         ta[p] = LOC;
         td[p] = 16'(16'h5000 + p);
      end
      step();
      n_chk++;
      if (eject_port !== 4'b0001 || local_data !== 16'h5000) begin
         n_fail++;
         $display("FAIL reset_mid_first: ej=%b data=%h want 0001/5000", eject_port, local_data);
      end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int p = 0; p < 4; p++) begin
            tv[p] = 1'($urandom_range(0, 1));
            ta[p] = ($urandom_range(0, 1) == 1) ? LOC : 6'($urandom);
            td[p] = 16'($urandom);
         end
         ready = ($urandom_range(0, 2) == 0);
         step();
         for (int p = 0; p < 4; p++) begin
            n_chk++;
            if (ov[p] !== exp_v[p] || (exp_v[p] && (oa[p] !== exp_a[p] || od[p] !== exp_d[p]))) begin
               n_fail++;
               $display("FAIL rand_fwd[%0d] port %0d: v=%b a=%h d=%h want %b/%h/%h", c, p, ov[p], oa[p], od[p], exp_v[p], exp_a[p], exp_d[p]);
            end
         end
         n_chk++;
         if (eject_port !== exp_ej || fifo_full !== (mq.size() == DEPTH)) begin
            n_fail++;
            $display("FAIL rand_status[%0d]: ej=%b full=%b want %b/%b", c, eject_port, fifo_full, exp_ej, mq.size() == DEPTH);
         end
         n_chk++;
         if (local_valid !== (mq.size() > 0) ||
             (mq.size() > 0 && (local_ad !== mq[0].addr || local_data !== mq[0].data))) begin
            n_fail++;
            $display("FAIL rand_head[%0d]: lv=%b ad=%h d=%h want %0d entries", c, local_valid, local_ad, local_data, mq.size());
         end
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_single_match();
      test_no_match();
      test_fifo_full();
      test_drain_order();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
